caliptra_prim_blank_ctrl: RTL and testbench

Sequencer that generates the enable for a `caliptra_prim_blanker` stage. It opens the blanker only after a settle interval following a consumer request, and re-blanks immediately on release or kill. It then holds a guard interval before the next request is accepted. It sits directly upstream of the blanker's `en_i` and talks a 4-phase req/ack handshake to the consumer.

---
 rtl/caliptra_prim_blank_ctrl_pkg.sv | 17 +
 rtl/caliptra_prim_blank_ctrl_flop.sv | 25 ++
 rtl/caliptra_prim_blank_ctrl.sv | 118 +++++++++++
 tb/tb_caliptra_prim_blank_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/caliptra_prim_blank_ctrl_pkg.sv
// Shared definitions for the blanker enable sequencer.
//   StateW  : width of the sparse state encoding
//   state_e : FSM states; every pair of encodings differs in at least 3 bits,
//             so a single or double bit upset cannot land on another legal state.
package caliptra_prim_blank_ctrl_pkg;

    localparam int StateW = 6;

    typedef enum logic [StateW-1:0] {
        StIdle   = 6'b001110,
        StSettle = 6'b110100,
        StOpen   = 6'b101011,
        StGuard  = 6'b010111,
        StError  = 6'b011001
    } state_e;

endpackage

// File: rtl/caliptra_prim_blank_ctrl_flop.sv
// Plain register with asynchronous active-low reset, kept as its own module so
// the sparse state encoding it holds is preserved through synthesis.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset, loads ResetValue
//   d_i    : next value
//   q_o    : registered value
module caliptra_prim_blank_ctrl_flop #(
    parameter int              Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= ResetValue;
        end else begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/caliptra_prim_blank_ctrl.sv
// Enable sequencer for a downstream blanker. A 4-phase req/ack consumer asks
// for the blanker to open; the enable rises after a settle interval, drops at
// once on release or kill, and a guard interval of blanking is enforced before
// another request is taken.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   req_i  : consumer request (4-phase)
//   kill_i : force blanking (e.g. escalation)
//   ack_o  : handshake acknowledge
//   en_o   : blanker enable, 1 passes data
//   err_o  : sticky FSM integrity error
//
// state  | meaning
// Idle   | blanked, waiting for a request
// Settle | request accepted, counting settle cycles
// Open   | blanker passing data, ack high
// Guard  | blanked again, ack held until guard done and request dropped
// Error  | illegal state seen, terminal until reset
module caliptra_prim_blank_ctrl
    import caliptra_prim_blank_ctrl_pkg::*;
#(
    parameter int unsigned SettleCycles = 2,
    parameter int unsigned GuardCycles  = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic kill_i,
    output logic ack_o,
    output logic en_o,
    output logic err_o
);

    localparam int unsigned MaxCycles = (SettleCycles > GuardCycles) ? SettleCycles : GuardCycles;
    localparam int          CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
    localparam logic [CntW-1:0] GuardLast  = CntW'(GuardCycles - 1);

    state_e            state_d;
    logic [StateW-1:0] state_raw_q;
    logic [CntW-1:0]   cnt_d, cnt_q;

    caliptra_prim_blank_ctrl_flop #(
        .Width      (StateW),
        .ResetValue (StateW'(StIdle))
    ) u_state_regs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (state_d),
        .q_o    (state_raw_q)
    );

    always_comb begin
        state_d = StError;
        cnt_d   = cnt_q;
        case (state_raw_q)
            StIdle: begin
                if (req_i && !kill_i) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StSettle: begin
                if (kill_i) begin
                    state_d = StGuard;
                    cnt_d   = '0;
                end else if (!req_i) begin
                    // Withdrawn before the blanker ever opened: no guard needed.
                    state_d = StIdle;
                end else if (cnt_q == SettleLast) begin
                    state_d = StOpen;
                end else begin
                    state_d = StSettle;
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            StOpen: begin
                if (kill_i || !req_i) begin
                    state_d = StGuard;
                    cnt_d   = '0;
                end else begin
                    state_d = StOpen;
                end
            end
            StGuard: begin
                if ((cnt_q == GuardLast) && !req_i) begin
                    state_d = StIdle;
                end else begin
                    state_d = StGuard;
                    if (cnt_q != GuardLast) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StError: state_d = StError;
            default: state_d = StError;
        endcase
    end

    // Outputs decode the next state and are registered, so nothing from the
    // inputs reaches the pins combinationally and reset clears en_o at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            en_o  <= 1'b0;
            ack_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_o  <= (state_d == StOpen);
            ack_o <= (state_d == StOpen) || (state_d == StGuard);
            err_o <= (state_d == StError);
        end
    end

endmodule

// File: tb/tb_caliptra_prim_blank_ctrl.sv
// Two instances (Settle=2/Guard=1 and Settle=3/Guard=3) share stimulus. A
// timestamp-based model predicts {en,ack,err} per edge into per-instance
// queues; an independent monitor pops and compares after each rising edge.
module tb_caliptra_prim_blank_ctrl;

    localparam int S0 = 2, G0 = 1;
    localparam int S1 = 3, G1 = 3;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_OPEN = 2, P_GUARD = 3, P_ERR = 4;

    logic clk_i = 1'b0;
    logic rst_ni, req_i, kill_i;
    logic en0, ack0, err0, en1, ack1, err1;

    caliptra_prim_blank_ctrl #(.SettleCycles(S0), .GuardCycles(G0)) dut (
        .clk_i (clk_i), .rst_ni (rst_ni), .req_i (req_i), .kill_i (kill_i),
        .ack_o (ack0), .en_o (en0), .err_o (err0)
    );

    caliptra_prim_blank_ctrl #(.SettleCycles(S1), .GuardCycles(G1)) dut1 (
        .clk_i (clk_i), .rst_ni (rst_ni), .req_i (req_i), .kill_i (kill_i),
        .ack_o (ack1), .en_o (en1), .err_o (err1)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    logic [2:0] exp_q0[$];
    logic [2:0] exp_q1[$];

    int phase [2];
    int t0    [2];
    int s_cfg [2];
    int g_cfg [2];
    int cyc = 0;

    // Reference: open exactly SettleCycles edges after acceptance, leave the
    // guard once GuardCycles edges have elapsed and the request is low.
    task automatic step_model(input int i, input logic r, input logic k,
                              input logic rst_low, input logic inject,
                              output logic [2:0] e);
        if (rst_low) begin
            phase[i] = P_IDLE;
        end else if (inject) begin
            phase[i] = P_ERR;
        end else begin
            case (phase[i])
                P_IDLE: if (r && !k) begin phase[i] = P_SETTLE; t0[i] = cyc; end
                P_SETTLE: begin
                    if (k) begin phase[i] = P_GUARD; t0[i] = cyc; end
                    else if (!r) phase[i] = P_IDLE;
                    else if (cyc - t0[i] >= s_cfg[i]) phase[i] = P_OPEN;
                end
                P_OPEN: if (k || !r) begin phase[i] = P_GUARD; t0[i] = cyc; end
                P_GUARD: if ((cyc - t0[i] >= g_cfg[i]) && !r) phase[i] = P_IDLE;
                default: phase[i] = P_ERR;
            endcase
        end
        e = {phase[i] == P_OPEN, (phase[i] == P_OPEN) || (phase[i] == P_GUARD), phase[i] == P_ERR};
    endtask

    task automatic advance(input logic inject0);
        logic [2:0] e;
        step_model(0, req_i, kill_i, !rst_ni, inject0, e);
        exp_q0.push_back(e);
        step_model(1, req_i, kill_i, !rst_ni, 1'b0, e);
        exp_q1.push_back(e);
        cyc++;
    endtask

    task automatic tick(input logic r, input logic k);
        @(negedge clk_i);
        req_i  = r;
        kill_i = k;
        advance(1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        rst_ni = 1'b0;
        req_i  = 1'b0;
        kill_i = 1'b0;
        #1;
        total++;
        if ({en0, ack0, err0, en1, ack1, err1} !== 6'b0) begin
            bad++;
            $display("FAIL async_reset t=%0t got en/ack/err dut0=%b%b%b dut1=%b%b%b want all 0",
                     $time, en0, ack0, err0, en1, ack1, err1);
        end
        advance(1'b0);
        repeat (n - 1) begin
            @(negedge clk_i);
            advance(1'b0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        advance(1'b0);
    endtask

    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                total++;
                if ({en0, ack0, err0} !== e) begin
                    bad++;
                    $display("FAIL dut0 t=%0t got en/ack/err=%b%b%b want=%b", $time, en0, ack0, err0, e);
                end
            end
            if (exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                total++;
                if ({en1, ack1, err1} !== e) begin
                    bad++;
                    $display("FAIL dut1 t=%0t got en/ack/err=%b%b%b want=%b", $time, en1, ack1, err1, e);
                end
            end
        end
    end

    initial begin
        logic r;
        s_cfg[0] = S0; g_cfg[0] = G0;
        s_cfg[1] = S1; g_cfg[1] = G1;
        phase[0] = P_IDLE; phase[1] = P_IDLE;
        t0[0] = 0; t0[1] = 0;
        rst_ni = 1'b0;
        req_i  = 1'b0;
        kill_i = 1'b0;

        do_reset(3);

        // Basic open/close.
        repeat (2) tick(1'b0, 1'b0);
        repeat (7) tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);

        // Withdrawal during settle.
        tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);

        // Kill while open, request held well past the guard.
        repeat (5) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (9) tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);

        // Kill together with request during settle.
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (5) tick(1'b0, 1'b0);

        // Re-request inside the guard window.
        repeat (6) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b0);
        repeat (6) tick(1'b1, 1'b0);
        repeat (5) tick(1'b0, 1'b0);

        // Randomized consumer with occasional kills.
        r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) r = ~r;
            tick(r, ($urandom_range(15) == 0));
        end

        // Reset asserted while both instances are open.
        repeat (3) tick(1'b0, 1'b0);
        repeat (6) tick(1'b1, 1'b0);
        do_reset(2);
        repeat (3) tick(1'b0, 1'b0);

        // Illegal state encoding on the first instance.
        @(negedge clk_i);
        req_i  = 1'b0;
        kill_i = 1'b0;
        force dut.u_state_regs.q_o = 6'b000000;
        advance(1'b1);
        @(negedge clk_i);
        release dut.u_state_regs.q_o;
        advance(1'b0);
        for (int i = 0; i < 12; i++) tick(($urandom_range(1) == 1), ($urandom_range(3) == 0));
        do_reset(2);
        repeat (2) tick(1'b0, 1'b0);
        repeat (6) tick(1'b1, 1'b0);
        repeat (4) tick(1'b0, 1'b0);

        repeat (2) @(posedge clk_i);
        #2;
        total++;
        if ((exp_q0.size() != 0) || (exp_q1.size() != 0)) begin
            bad++;
            $display("FAIL drain got q0=%0d q1=%0d pending want 0", exp_q0.size(), exp_q1.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
